// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the shift arbiter slice.
//   DATA_WIDTH / SHAMT_WIDTH : default operand width and fixed shift-amount width
//   SHIFT_*                  : Shiftop encodings (2'b01 is reserved)
//   REQ_ALU / REQ_LSU        : requester ids returned on resp_id
//   slot_state_t             : output slot occupancy
package shift_arbiter_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter shared by both requesters.
//   A       : operand
//   B       : shift amount (0..31)
//   Shiftop : 00 SLL, 10 SRL, 11 SRA, 01 reserved (result forced to zero)
//   Result  : shifted operand
module shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [4:0]       B,
  input  logic [1:0]       Shiftop,
  output logic [WIDTH-1:0] Result
);
  import shift_arbiter_pkg::*;

  always_comb begin
    Result = '0;
    case (Shiftop)
      SHIFT_SLL: Result = A << B;
      SHIFT_SRL: Result = A >> B;
      SHIFT_SRA: Result = WIDTH'($signed(A) >>> B);
      default:   Result = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between the ALU issue path (port 0)
// and the load/store alignment path (port 1). Results land in a single-entry
// output slot that may refill in the same cycle it drains.
//   clk, rst               : clock, synchronous active-high reset
//   req{0,1}_valid/ready   : request handshake
//   req{0,1}_A/_B/_op      : operand, shift amount, Shiftop
//   resp_valid/ready       : response handshake
//   resp_data, resp_id     : shift result and issuing requester
//
// state      | meaning
// SLOT_EMPTY | no result held, resp_valid low
// SLOT_FULL  | result held in resp_data/resp_id, resp_valid high
module shift_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [4:0]            req0_B,
  input  logic [1:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [4:0]            req1_B,
  input  logic [1:0]            req1_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_id
);
  import shift_arbiter_pkg::*;

  slot_state_t           state_q, state_d;
  logic                  last_grant_q;
  logic                  can_accept;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_A;
  logic [4:0]            sel_B;
  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] shift_result;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = REQ_ALU;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = REQ_LSU;
    end
  end

  // A full slot being drained this cycle can take a new result at the same edge.
  assign can_accept = !rst && ((state_q == SLOT_EMPTY) || resp_ready);
  assign accept     = can_accept && grant_valid;
  assign req0_ready = can_accept && grant_valid && (grant_id == REQ_ALU);
  assign req1_ready = can_accept && grant_valid && (grant_id == REQ_LSU);

  assign sel_A  = (grant_id == REQ_LSU) ? req1_A  : req0_A;
  assign sel_B  = (grant_id == REQ_LSU) ? req1_B  : req0_B;
  assign sel_op = (grant_id == REQ_LSU) ? req1_op : req0_op;

  shifter #(
    .WIDTH (DATA_WIDTH)
  ) u_shifter (
    .A       (sel_A),
    .B       (sel_B),
    .Shiftop (sel_op),
    .Result  (shift_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (resp_ready && !accept) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SLOT_EMPTY;
      last_grant_q <= REQ_LSU;
      resp_data    <= '0;
      resp_id      <= REQ_ALU;
    end else begin
      state_q <= state_d;
      if (accept) begin
        resp_data    <= shift_result;
        resp_id      <= grant_id;
        last_grant_q <= grant_id;
      end
    end
  end

  assign resp_valid = (state_q == SLOT_FULL);

endmodule
